// File: rtl/pe_core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_core_pkg                                                                |
// | Shared defaults, row-index width helper and drain state type for PE core.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pe_core_pkg;

  localparam int PE_DATA_WIDTH = 32;
  localparam int PE_ARRAY_ROWS = 8;

  // A single-row array still needs a 1-bit row index.
  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } drain_state_e;

endpackage
`default_nettype wire

// File: rtl/mac_drain_slot_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_drain_slot_buf                                                         |
// | Two-slot result vector store: whole-vector write, registered-select row    |
// | read mux.                                                                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mac_drain_slot_buf
  import pe_core_pkg::*;
#(
  parameter int  DATA_WIDTH = PE_DATA_WIDTH,
  parameter int  ARRAY_ROWS = PE_ARRAY_ROWS,
  localparam int ROW_W      = row_w(ARRAY_ROWS),
  localparam int VEC_W      = DATA_WIDTH * ARRAY_ROWS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic                  wr_sel_i,
  input  logic [VEC_W-1:0]      wr_data_i,
  input  logic                  rd_sel_i,
  input  logic [ROW_W-1:0]      rd_row_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [VEC_W-1:0] slot_q [2];
  logic [VEC_W-1:0] slot_d [2];

  always_comb begin
    slot_d = slot_q;
    if (wr_en_i) slot_d[wr_sel_i] = wr_data_i;
  end

  // Cleared on reset so the data output reads zero until the first capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
    end
  end

  assign rd_data_o = slot_q[rd_sel_i][32'(rd_row_i) * DATA_WIDTH +: DATA_WIDTH];

endmodule
`default_nettype wire

// File: rtl/mac_result_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_result_drain                                                           |
// | Captures MAC result vectors into a ping-pong store and streams one row per |
// | beat. Optional capture clamp: define PE_DRAIN_RELU_EN.                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mac_result_drain
  import pe_core_pkg::*;
#(
  parameter int  DATA_WIDTH = PE_DATA_WIDTH,
  parameter int  ARRAY_ROWS = PE_ARRAY_ROWS,
  localparam int ROW_W      = row_w(ARRAY_ROWS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             mac_valid_i,
  input  logic [DATA_WIDTH*ARRAY_ROWS-1:0] mac_result_i,
  output logic                             in_ready_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [DATA_WIDTH-1:0]            out_data_o,
  output logic [ROW_W-1:0]                 out_row_o,
  output logic                             out_last_o,
  output logic                             overflow_o,
  input  logic                             clr_overflow_i
);

  localparam int              VEC_W    = DATA_WIDTH * ARRAY_ROWS;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_ROWS - 1);

  drain_state_e     count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic [ROW_W-1:0] row_idx_q, row_idx_d;

  logic             in_ready, out_valid, capture, beat, last_pop;
  logic [VEC_W-1:0] store_vec;

  generate
    for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_row
`ifdef PE_DRAIN_RELU_EN
      assign store_vec[r*DATA_WIDTH +: DATA_WIDTH] =
        mac_result_i[r*DATA_WIDTH + DATA_WIDTH - 1] ? '0 : mac_result_i[r*DATA_WIDTH +: DATA_WIDTH];
`else
      assign store_vec[r*DATA_WIDTH +: DATA_WIDTH] = mac_result_i[r*DATA_WIDTH +: DATA_WIDTH];
`endif
    end
  endgenerate

  always_comb begin
    in_ready  = (count_q != FULL);
    out_valid = (count_q != EMPTY);
    capture   = mac_valid_i && in_ready;
    beat      = out_valid && out_ready_i;
    last_pop  = beat && (row_idx_q == LAST_ROW);

    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    row_idx_d  = row_idx_q;
    overflow_d = overflow_q;

    if (capture) wr_ptr_d = ~wr_ptr_q;
    if (last_pop) rd_ptr_d = ~rd_ptr_q;

    if (beat) row_idx_d = last_pop ? '0 : row_idx_q + ROW_W'(1);

    // Simultaneous capture and pop leaves occupancy unchanged.
    if (capture && !last_pop)      count_d = (count_q == EMPTY) ? ONE : FULL;
    else if (!capture && last_pop) count_d = (count_q == FULL) ? ONE : EMPTY;

    // A drop in the same cycle as a clear wins.
    if (mac_valid_i && !in_ready) overflow_d = 1'b1;
    else if (clr_overflow_i)      overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= EMPTY;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      row_idx_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      row_idx_q  <= row_idx_d;
      overflow_q <= overflow_d;
    end
  end

  mac_drain_slot_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARRAY_ROWS (ARRAY_ROWS)
  ) u_slot_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (capture),
    .wr_sel_i  (wr_ptr_q),
    .wr_data_i (store_vec),
    .rd_sel_i  (rd_ptr_q),
    .rd_row_i  (row_idx_q),
    .rd_data_o (out_data_o)
  );

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid;
  assign out_row_o   = row_idx_q;
  assign out_last_o  = (row_idx_q == LAST_ROW);
  assign overflow_o  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_result_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mac_result_drain                                                        |
// | Self-checking bench for mac_result_drain against a queue-based model.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mac_result_drain;

  localparam int DW = 32;
  localparam int AR = 8;
  localparam int RW = 3;
  localparam int VW = DW * AR;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mac_valid_i;
  logic [VW-1:0] mac_result_i;
  logic          in_ready_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [RW-1:0] out_row_o;
  logic          out_last_o;
  logic          overflow_o;
  logic          clr_overflow_i;

  int n_pass  = 0;
  int n_total = 0;

  // Model: FIFO of stored vectors (at most two), current row, sticky drop flag.
  logic [VW-1:0] mq[$];
  int            m_row;
  bit            m_ovf;

  mac_result_drain #(.DATA_WIDTH(DW), .ARRAY_ROWS(AR)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mac_valid_i    (mac_valid_i),
    .mac_result_i   (mac_result_i),
    .in_ready_o     (in_ready_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .out_row_o      (out_row_o),
    .out_last_o     (out_last_o),
    .overflow_o     (overflow_o),
    .clr_overflow_i (clr_overflow_i)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input logic [VW-1:0] v, input int idx);
    return v[idx*DW +: DW];
  endfunction

  function automatic logic [VW-1:0] relu_model(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
`ifdef PE_DRAIN_RELU_EN
    for (int i = 0; i < AR; i++)
      if ($signed(v[i*DW +: DW]) < 0) r[i*DW +: DW] = '0;
`endif
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < AR; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  function automatic bit e_valid();
    return mq.size() != 0;
  endfunction

  function automatic bit e_ready();
    return mq.size() < 2;
  endfunction

  function automatic logic [DW-1:0] e_data();
    return (mq.size() != 0) ? word(mq[0], m_row) : '0;
  endfunction

  // Drive inputs at the falling edge, clock once, advance the model, return at next falling edge.
  task automatic tick(input bit v, input logic [VW-1:0] d, input bit rdy, input bit clr);
    bit can_in, pop;
    mac_valid_i    = v;
    mac_result_i   = d;
    out_ready_i    = rdy;
    clr_overflow_i = clr;
    can_in = (mq.size() < 2);
    pop    = (mq.size() != 0) && rdy;
    @(posedge clk);
    if (pop) begin
      if (m_row == AR - 1) begin
        void'(mq.pop_front());
        m_row = 0;
      end else begin
        m_row++;
      end
    end
    if (v && can_in) mq.push_back(relu_model(d));
    if (v && !can_in) m_ovf = 1'b1;
    else if (clr)     m_ovf = 1'b0;
    @(negedge clk);
    mac_valid_i    = 1'b0;
    clr_overflow_i = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_row = 0;
    m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    logic [VW-1:0] v;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_total++; if (in_ready_o !== 1'b1) $display("FAIL rst_in_ready: got %b need 1", in_ready_o); else n_pass++;
    n_total++; if (out_valid_o !== 1'b0) $display("FAIL rst_out_valid: got %b need 0", out_valid_o); else n_pass++;
    n_total++; if (overflow_o !== 1'b0) $display("FAIL rst_overflow: got %b need 0", overflow_o); else n_pass++;
    n_total++; if ({out_data_o, out_row_o, out_last_o} !== '0)
      $display("FAIL rst_outputs: got data %0h row %0d last %b need all 0", out_data_o, out_row_o, out_last_o);
    else n_pass++;
    // Fill, overflow and partly stream, then reset asynchronously mid-stream.
    for (int i = 0; i < 3; i++) tick(1'b1, rand_vec(), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_total++; if ({in_ready_o, out_valid_o, overflow_o} !== 3'b100)
      $display("FAIL rst_mid_flags: got rdy/vld/ovf %b%b%b need 100", in_ready_o, out_valid_o, overflow_o);
    else n_pass++;
    n_total++; if (out_row_o !== '0) $display("FAIL rst_mid_row: got %0d need 0", out_row_o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    v = rand_vec();
    tick(1'b1, v, 1'b0, 1'b0);
    n_total++; if (out_valid_o !== 1'b1 || out_row_o !== '0 || out_data_o !== word(relu_model(v), 0))
      $display("FAIL rst_restart: got vld %b row %0d data %0h need 1 0 %0h",
               out_valid_o, out_row_o, out_data_o, word(relu_model(v), 0));
    else n_pass++;
    for (int i = 0; i < AR; i++) tick(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_single();
    logic [VW-1:0] v;
    for (int i = 0; i < AR; i++) v[i*DW +: DW] = DW'((i + 1) * 10);
    tick(1'b1, v, 1'b1, 1'b0);
    for (int i = 0; i < AR; i++) begin
      n_total++;
      if (out_valid_o !== 1'b1 || out_data_o !== DW'((i + 1) * 10) || out_row_o !== RW'(i) ||
          out_last_o !== (i == AR - 1))
        $display("FAIL single_beat%0d: got vld %b data %0d row %0d last %b need 1 %0d %0d %b",
                 i, out_valid_o, out_data_o, out_row_o, out_last_o, (i + 1) * 10, i, i == AR - 1);
      else n_pass++;
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    n_total++; if (out_valid_o !== 1'b0) $display("FAIL single_done: got vld %b need 0", out_valid_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] v, s;
    int idx = 0;
    bit rdy;
    v = rand_vec();
    s = relu_model(v);
    tick(1'b1, v, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 40 && idx < AR; cyc++) begin
      rdy = (cyc % 2 == 0);
      n_total++;
      if (out_valid_o !== 1'b1 || out_row_o !== RW'(idx) || out_data_o !== word(s, idx) ||
          out_last_o !== (idx == AR - 1))
        $display("FAIL bp_cyc%0d: got vld %b row %0d data %0h last %b need 1 %0d %0h %b",
                 cyc, out_valid_o, out_row_o, out_data_o, out_last_o, idx, word(s, idx), idx == AR - 1);
      else n_pass++;
      if (rdy) idx++;
      tick(1'b0, '0, rdy, 1'b0);
    end
    n_total++; if (idx != AR || out_valid_o !== 1'b0)
      $display("FAIL bp_done: got rows %0d vld %b need %0d 0", idx, out_valid_o, AR);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [VW-1:0] v1, v2;
    v1 = rand_vec();
    v2 = rand_vec();
    tick(1'b1, v1, 1'b0, 1'b0);
    tick(1'b1, v2, 1'b0, 1'b0);
    tick(1'b1, rand_vec(), 1'b0, 1'b0);
    n_total++; if (overflow_o !== 1'b1 || in_ready_o !== 1'b0)
      $display("FAIL ovf_set: got ovf %b rdy %b need 1 0", overflow_o, in_ready_o);
    else n_pass++;
    tick(1'b0, '0, 1'b0, 1'b1);
    n_total++; if (overflow_o !== 1'b0) $display("FAIL ovf_clr: got %b need 0", overflow_o); else n_pass++;
    tick(1'b1, rand_vec(), 1'b0, 1'b1);
    n_total++; if (overflow_o !== 1'b1) $display("FAIL ovf_set_prio: got %b need 1", overflow_o); else n_pass++;
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 2 * AR; i++) begin
      n_total++;
      if (out_valid_o !== 1'b1 || out_data_o !== word(relu_model(i < AR ? v1 : v2), i % AR) ||
          out_row_o !== RW'(i % AR))
        $display("FAIL ovf_drain%0d: got vld %b data %0h row %0d need 1 %0h %0d", i, out_valid_o,
                 out_data_o, out_row_o, word(relu_model(i < AR ? v1 : v2), i % AR), i % AR);
      else n_pass++;
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    n_total++; if (out_valid_o !== 1'b0 || overflow_o !== 1'b0)
      $display("FAIL ovf_done: got vld %b ovf %b need 0 0", out_valid_o, overflow_o);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    logic [VW-1:0] v1, v2;
    v1 = rand_vec();
    v2 = rand_vec();
    tick(1'b1, v1, 1'b1, 1'b0);
    for (int i = 0; i < AR - 1; i++) tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b1, v2, 1'b1, 1'b0);
    n_total++;
    if (out_valid_o !== 1'b1 || in_ready_o !== 1'b1 || overflow_o !== 1'b0 || out_row_o !== '0 ||
        out_data_o !== word(relu_model(v2), 0))
      $display("FAIL same_cycle: got vld %b rdy %b ovf %b row %0d data %0h need 1 1 0 0 %0h",
               out_valid_o, in_ready_o, overflow_o, out_row_o, out_data_o, word(relu_model(v2), 0));
    else n_pass++;
    for (int i = 0; i < AR; i++) begin
      n_total++;
      if (out_data_o !== word(relu_model(v2), i) || out_row_o !== RW'(i))
        $display("FAIL same_drain%0d: got data %0h row %0d need %0h %0d", i, out_data_o, out_row_o,
                 word(relu_model(v2), i), i);
      else n_pass++;
      tick(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_relu();
    logic [VW-1:0] v;
    logic [DW-1:0] exp_rows [4];
    v = rand_vec();
    v[0*DW +: DW] = -32'sd5;
    v[1*DW +: DW] = 32'd7;
    v[2*DW +: DW] = 32'h8000_0000;
    v[3*DW +: DW] = 32'h7FFF_FFFF;
`ifdef PE_DRAIN_RELU_EN
    exp_rows = '{32'd0, 32'd7, 32'd0, 32'h7FFF_FFFF};
`else
    exp_rows = '{32'hFFFF_FFFB, 32'd7, 32'h8000_0000, 32'h7FFF_FFFF};
`endif
    tick(1'b1, v, 1'b0, 1'b0);
    for (int i = 0; i < AR; i++) begin
      if (i < 4) begin
        n_total++;
        if (out_data_o !== exp_rows[i])
          $display("FAIL relu_row%0d: got %0h need %0h", i, out_data_o, exp_rows[i]);
        else n_pass++;
      end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    bit v, rdy, clr;
    for (int cyc = 0; cyc < 800; cyc++) begin
      v   = ($urandom_range(0, 99) < 45);
      rdy = ($urandom_range(0, 99) < 60);
      clr = ($urandom_range(0, 99) < 5);
      tick(v, rand_vec(), rdy, clr);
      n_total++;
      if (in_ready_o !== e_ready() || out_valid_o !== e_valid() || overflow_o !== m_ovf)
        $display("FAIL rand_flags%0d: got rdy/vld/ovf %b%b%b need %b%b%b", cyc, in_ready_o,
                 out_valid_o, overflow_o, e_ready(), e_valid(), m_ovf);
      else n_pass++;
      if (e_valid()) begin
        n_total++;
        if (out_data_o !== e_data() || out_row_o !== RW'(m_row) || out_last_o !== (m_row == AR - 1))
          $display("FAIL rand_beat%0d: got data %0h row %0d last %b need %0h %0d %b", cyc,
                   out_data_o, out_row_o, out_last_o, e_data(), m_row, m_row == AR - 1);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    mac_valid_i    = 1'b0;
    mac_result_i   = '0;
    out_ready_i    = 1'b0;
    clr_overflow_i = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_same_cycle();
    test_relu();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
